// File: rtl/cb_combine_pkg.sv
// Shared types, widths and LLR saturation helper for the CB combine engine.
package cb_combine_pkg;

  localparam int LLR_W        = 8;
  localparam int LLR_PER_WORD = 6;
  localparam int ADDR_W       = 11;
  localparam int USER_NUM     = 8;
  localparam int USER_W       = 3;
  localparam int WORD_W       = LLR_W * LLR_PER_WORD;

  // Symmetric clamp range: -128 is excluded so negation stays representable.
  localparam logic signed [LLR_W-1:0] LLR_MAX = {1'b0, {(LLR_W-1){1'b1}}};
  localparam logic signed [LLR_W-1:0] LLR_MIN = {1'b1, {(LLR_W-2){1'b0}}, 1'b1};

  typedef enum logic [5:0] {
    ST_IDLE     = 6'b000001,
    ST_LOAD     = 6'b000010,
    ST_RUN      = 6'b000100,
    ST_DRAIN    = 6'b001000,
    ST_DONE     = 6'b010000,
    ST_WAIT_REL = 6'b100000
  } state_t;

  function automatic logic signed [LLR_W-1:0] sat_llr(input logic signed [LLR_W:0] sum);
    logic signed [LLR_W-1:0] res;
    if (sum > LLR_W'(LLR_MAX) && sum > 0)
      res = LLR_MAX;
    else if (sum < 0 && sum < LLR_MIN)
      res = LLR_MIN;
    else
      res = sum[LLR_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/cb_combine_engine_llr_sat_adder.sv
// Parallel per-lane LLR soft-combine: in + harq (or in alone on first transmission), clamped.
module llr_sat_adder
  import cb_combine_pkg::*;
#(
  parameter int LANES = LLR_PER_WORD
) (
  input  logic [LLR_W*LANES-1:0] in_word,
  input  logic [LLR_W*LANES-1:0] harq_word,
  input  logic                   new_tx,
  output logic [LLR_W*LANES-1:0] sum_word
);

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic signed [LLR_W-1:0] a;
    logic signed [LLR_W-1:0] b;
    logic signed [LLR_W:0]   s;

    assign a = in_word[j*LLR_W +: LLR_W];
    assign b = new_tx ? '0 : harq_word[j*LLR_W +: LLR_W];
    assign s = {a[LLR_W-1], a} + {b[LLR_W-1], b};
    assign sum_word[j*LLR_W +: LLR_W] = sat_llr(s);
  end

endmodule

// File: rtl/cb_combine_engine.sv
// Combine responder: reads one user's CB from the ping-pong buffer, soft-combines it with
// the HARQ buffer, writes it back and pulses completion; tracks the per-user read bank.
module cb_combine_engine
  import cb_combine_pkg::*;
(
  input  logic                       i_core_clk,
  input  logic                       i_rx_rstn,
  input  logic                       i_combine_process_request,
  input  logic [3:0]                 i_combine_user_index,
  input  logic [ADDR_W-1:0]          i_cb_word_num,
  input  logic [USER_NUM-1:0]        i_user_new_tx,
  output logic                       o_current_cb_combine_comp,
  output logic [USER_NUM-1:0]        o_rd_bank,
  output logic                       o_inbuf_rd_en,
  output logic [USER_W-1:0]          o_inbuf_rd_user,
  output logic                       o_inbuf_rd_bank,
  output logic [ADDR_W-1:0]          o_inbuf_rd_addr,
  input  logic [WORD_W-1:0]          i_inbuf_rd_data,
  output logic                       o_harq_rd_en,
  output logic [USER_W+ADDR_W-1:0]   o_harq_rd_addr,
  input  logic [WORD_W-1:0]          i_harq_rd_data,
  output logic                       o_harq_wr_en,
  output logic [USER_W+ADDR_W-1:0]   o_harq_wr_addr,
  output logic [WORD_W-1:0]          o_harq_wr_data
);

  state_t              state;
  logic [USER_W-1:0]   user_q;
  logic [ADDR_W-1:0]   num_q;
  logic [ADDR_W-1:0]   cnt;
  logic                idx_ok;
  logic                new_tx_q;
  logic                bank_q;
  logic                drain_q;

  logic                vld_p1;
  logic [ADDR_W-1:0]   addr_p1;
  logic [WORD_W-1:0]   sum_p1;

  assign o_inbuf_rd_user = user_q;
  assign o_inbuf_rd_bank = bank_q;

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      state                     <= ST_IDLE;
      user_q                    <= '0;
      num_q                     <= '0;
      cnt                       <= '0;
      idx_ok                    <= 1'b0;
      new_tx_q                  <= 1'b0;
      bank_q                    <= 1'b0;
      drain_q                   <= 1'b0;
      o_current_cb_combine_comp <= 1'b0;
      o_rd_bank                 <= '0;
      o_inbuf_rd_en             <= 1'b0;
      o_inbuf_rd_addr           <= '0;
      o_harq_rd_en              <= 1'b0;
      o_harq_rd_addr            <= '0;
    end else begin
      o_current_cb_combine_comp <= 1'b0;
      o_inbuf_rd_en             <= 1'b0;
      o_harq_rd_en              <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_combine_process_request) begin
            user_q <= i_combine_user_index[USER_W-1:0];
            idx_ok <= (i_combine_user_index < 4'(USER_NUM));
            num_q  <= i_cb_word_num;
            state  <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          new_tx_q <= i_user_new_tx[user_q];
          bank_q   <= o_rd_bank[user_q];
          drain_q  <= 1'b0;
          if (!idx_ok || num_q == '0) begin
            state <= ST_DONE;
          end else begin
            // Word 0 is issued on the way out of LOAD so reads start one cycle earlier.
            o_inbuf_rd_en   <= 1'b1;
            o_inbuf_rd_addr <= '0;
            o_harq_rd_en    <= !i_user_new_tx[user_q];
            o_harq_rd_addr  <= {user_q, ADDR_W'(0)};
            cnt             <= ADDR_W'(1);
            state           <= (num_q == ADDR_W'(1)) ? ST_DRAIN : ST_RUN;
          end
        end
        ST_RUN: begin
          o_inbuf_rd_en   <= 1'b1;
          o_inbuf_rd_addr <= cnt;
          o_harq_rd_en    <= !new_tx_q;
          o_harq_rd_addr  <= {user_q, cnt};
          cnt             <= cnt + ADDR_W'(1);
          if (cnt == num_q - ADDR_W'(1))
            state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          drain_q <= 1'b1;
          if (drain_q)
            state <= ST_DONE;
        end
        ST_DONE: begin
          o_current_cb_combine_comp <= 1'b1;
          if (idx_ok && num_q != '0)
            o_rd_bank[user_q] <= ~o_rd_bank[user_q];
          state <= ST_WAIT_REL;
        end
        ST_WAIT_REL: begin
          if (!i_combine_process_request)
            state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  llr_sat_adder #(.LANES(LLR_PER_WORD)) u_adder (
    .in_word   (i_inbuf_rd_data),
    .harq_word (i_harq_rd_data),
    .new_tx    (new_tx_q),
    .sum_word  (sum_p1)
  );

  // Stage p1: read data returning from both RAMs; stage p2: registered write-back.
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      vld_p1         <= 1'b0;
      addr_p1        <= '0;
      o_harq_wr_en   <= 1'b0;
      o_harq_wr_addr <= '0;
      o_harq_wr_data <= '0;
    end else begin
      vld_p1       <= o_inbuf_rd_en;
      addr_p1      <= o_inbuf_rd_addr;
      o_harq_wr_en <= vld_p1;
      if (vld_p1) begin
        o_harq_wr_addr <= {user_q, addr_p1};
        o_harq_wr_data <= sum_p1;
      end
    end
  end

endmodule
